// File: rtl/fft_pkg.sv
// Shared definitions for the radix-4 FFT butterfly.
// Holds the data widths, the complex slice layout, the W16 twiddle ROM
// and the output saturation helper.
package fft_pkg;

    localparam int unsigned DW      = 17;           // Q8.8 component width
    localparam int unsigned TW_FRAC = 8;            // twiddle fraction bits
    localparam int unsigned CW      = 2 * DW;       // one complex slice
    localparam int unsigned NUM_PTS = 4;            // complex points per beat
    localparam int unsigned BUS_W   = NUM_PTS * CW; // packed calc_in/calc_out
    localparam int unsigned AW      = DW + 2;       // adder-tree width
    localparam int unsigned TWW     = 10;           // Q1.8 twiddle needs +-256
    localparam int unsigned PW      = AW + TWW + 1; // full complex-product width

    // Bit positions of the components inside one complex slice.
    localparam int unsigned RE_LSB = DW;
    localparam int unsigned IM_LSB = 0;

    localparam int SAT_MAX = (2 ** (DW - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DW - 1));

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TWW-1:0] re;
        logic signed [TWW-1:0] im;
    } tw_t;

    // rotation[2] selects which pass of the 16-point transform this beat is.
    typedef enum logic {
        StageTwiddle = 1'b0,
        StageBypass  = 1'b1
    } stage_e;

    // W16^p = cos(2*pi*p/16) - j*sin(2*pi*p/16) in Q1.8, p = 0..9.
    function automatic tw_t tw_rom(input logic [3:0] p);
        tw_t w;
        case (p)
            4'd0:    w = '{re:  10'sd256, im:  10'sd0};
            4'd1:    w = '{re:  10'sd237, im: -10'sd98};
            4'd2:    w = '{re:  10'sd181, im: -10'sd181};
            4'd3:    w = '{re:  10'sd98,  im: -10'sd237};
            4'd4:    w = '{re:  10'sd0,   im: -10'sd256};
            4'd5:    w = '{re: -10'sd98,  im: -10'sd237};
            4'd6:    w = '{re: -10'sd181, im: -10'sd181};
            4'd7:    w = '{re: -10'sd237, im: -10'sd98};
            4'd8:    w = '{re: -10'sd256, im:  10'sd0};
            4'd9:    w = '{re: -10'sd237, im:  10'sd98};
            default: w = '{re:  10'sd256, im:  10'sd0};  // p > 9 never selected
        endcase
        return w;
    endfunction

    // Clamp a wide signed value to the DW-bit output range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [31:0] v);
        if (v > SAT_MAX) begin
            return DW'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            return DW'(SAT_MIN);
        end
        return v[DW-1:0];
    endfunction

endpackage

// File: rtl/radix4_fft_butterfly_if.sv
// Data bus of the radix-4 butterfly.
//   calc_in  : four packed complex inputs  (in1 at the LSB end)
//   rotation : twiddle select, sampled with calc_in
//   calc_out : four packed complex outputs (out1 at the LSB end)
// master drives calc_in/rotation, slave is the butterfly.
interface radix4_fft_butterfly_if;
    import fft_pkg::*;

    logic [BUS_W-1:0] calc_in;
    logic [2:0]       rotation;
    logic [BUS_W-1:0] calc_out;

    modport master (
        output calc_in,
        output rotation,
        input  calc_out
    );

    modport slave (
        input  calc_in,
        input  rotation,
        output calc_out
    );

endinterface

// File: rtl/cmplx_mult_q8.sv
// Signed complex multiply by a Q1.8 twiddle, arithmetic shift back to Q8.8
// (floor), then saturation to DW bits. Purely combinational.
//   y_re_i/y_im_i   : adder-tree result, AW bits signed
//   tw_re_i/tw_im_i : twiddle, TWW bits signed Q1.8
//   z_re_o/z_im_o   : saturated product, DW bits signed
module cmplx_mult_q8
    import fft_pkg::*;
(
    input  logic signed [AW-1:0]  y_re_i,
    input  logic signed [AW-1:0]  y_im_i,
    input  logic signed [TWW-1:0] tw_re_i,
    input  logic signed [TWW-1:0] tw_im_i,
    output logic signed [DW-1:0]  z_re_o,
    output logic signed [DW-1:0]  z_im_o
);

    logic signed [PW-1:0] yr, yi, tr, ti;
    logic signed [PW-1:0] re_full, im_full;
    logic signed [PW-1:0] re_sh, im_sh;

    always_comb begin
        // Widen before multiplying so the products are never truncated.
        yr = {{(PW - AW){y_re_i[AW-1]}}, y_re_i};
        yi = {{(PW - AW){y_im_i[AW-1]}}, y_im_i};
        tr = {{(PW - TWW){tw_re_i[TWW-1]}}, tw_re_i};
        ti = {{(PW - TWW){tw_im_i[TWW-1]}}, tw_im_i};

        re_full = (yr * tr) - (yi * ti);
        im_full = (yr * ti) + (yi * tr);

        re_sh = re_full >>> TW_FRAC;
        im_sh = im_full >>> TW_FRAC;

        z_re_o = sat_dw({{(32 - PW){re_sh[PW-1]}}, re_sh});
        z_im_o = sat_dw({{(32 - PW){im_sh[PW-1]}}, im_sh});
    end

endmodule

// File: rtl/radix4_fft_butterfly.sv
// Radix-4 DIF butterfly with twiddle multiply, the arithmetic core of a
// 16-point FFT. One output register, a new beat every cycle.
//   clk : system clock
//   rst : synchronous active-high reset, clears calc_out
//   bus : slave side of radix4_fft_butterfly_if (calc_in, rotation, calc_out)
// y_k = sum_m in_m * (-j)^(m*k); out_k = sat(y_k * W16^(n*k)), where n comes
// from rotation[1:0] in the twiddled stage and the factor is 1 otherwise.
module radix4_fft_butterfly
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    radix4_fft_butterfly_if.slave bus
);

    cplx_t                 in_c;
    logic signed [AW-1:0]  xr [NUM_PTS];
    logic signed [AW-1:0]  xi [NUM_PTS];
    logic signed [AW-1:0]  y_re [NUM_PTS];
    logic signed [AW-1:0]  y_im [NUM_PTS];
    logic signed [DW-1:0]  z_re [NUM_PTS];
    logic signed [DW-1:0]  z_im [NUM_PTS];

    stage_e                stage;
    logic [1:0]            n_sel;

    logic [BUS_W-1:0]      calc_out_d, calc_out_q;

    // Unpack and sign-extend to the adder-tree width.
    always_comb begin
        in_c = '0;
        for (int m = 0; m < NUM_PTS; m++) begin
            in_c  = cplx_t'(bus.calc_in[m*CW +: CW]);
            xr[m] = {{(AW - DW){in_c.re[DW-1]}}, in_c.re};
            xi[m] = {{(AW - DW){in_c.im[DW-1]}}, in_c.im};
        end
    end

    // Multiplication by -j maps (re, im) -> (im, -re); by +j -> (-im, re).
    always_comb begin
        y_re[0] = xr[0] + xr[1] + xr[2] + xr[3];
        y_im[0] = xi[0] + xi[1] + xi[2] + xi[3];

        y_re[1] = xr[0] + xi[1] - xr[2] - xi[3];
        y_im[1] = xi[0] - xr[1] - xi[2] + xr[3];

        y_re[2] = xr[0] - xr[1] + xr[2] - xr[3];
        y_im[2] = xi[0] - xi[1] + xi[2] - xi[3];

        y_re[3] = xr[0] - xi[1] - xr[2] + xi[3];
        y_im[3] = xi[0] + xr[1] - xi[2] - xr[3];
    end

    assign stage = stage_e'(bus.rotation[2]);
    assign n_sel = (stage == StageBypass) ? 2'd0 : bus.rotation[1:0];

    // out1 always has twiddle 1, so it only needs saturation.
    assign z_re[0] = sat_dw({{(32 - AW){y_re[0][AW-1]}}, y_re[0]});
    assign z_im[0] = sat_dw({{(32 - AW){y_im[0][AW-1]}}, y_im[0]});

    for (genvar k = 1; k < NUM_PTS; k++) begin : g_mult
        logic [3:0] p_idx;
        tw_t        tw;

        assign p_idx = {2'b00, n_sel} * 4'(k);
        assign tw    = tw_rom(p_idx);

        cmplx_mult_q8 u_mult (
            .y_re_i  (y_re[k]),
            .y_im_i  (y_im[k]),
            .tw_re_i (tw.re),
            .tw_im_i (tw.im),
            .z_re_o  (z_re[k]),
            .z_im_o  (z_im[k])
        );
    end

    always_comb begin
        calc_out_d = '0;
        for (int k = 0; k < NUM_PTS; k++) begin
            calc_out_d[k*CW + RE_LSB +: DW] = z_re[k];
            calc_out_d[k*CW + IM_LSB +: DW] = z_im[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            calc_out_q <= '0;
        end else begin
            calc_out_q <= calc_out_d;
        end
    end

    assign bus.calc_out = calc_out_q;

endmodule

// File: tb/tb_radix4_fft_butterfly.sv
// Self-checking bench for radix4_fft_butterfly: directed beats, a full
// two-pass 16-point FFT, saturation and randomized back-to-back beats,
// all checked against a plain DFT-style reference model.
module tb_radix4_fft_butterfly;
    import fft_pkg::*;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    radix4_fft_butterfly_if bus ();

    radix4_fft_butterfly u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int xr [16];
    int xi [16];
    int fr [16];
    int fi [16];

    // ---------------- helpers ----------------
    function automatic logic [CW-1:0] mk(input int re, input int im);
        return {re[DW-1:0], im[DW-1:0]};
    endfunction

    function automatic int sre(input logic [BUS_W-1:0] v, input int q);
        logic signed [DW-1:0] t;
        t = v[q*CW + DW +: DW];
        return int'(t);
    endfunction

    function automatic int sim(input logic [BUS_W-1:0] v, input int q);
        logic signed [DW-1:0] t;
        t = v[q*CW +: DW];
        return int'(t);
    endfunction

    function automatic longint rnd(input real r);
        if (r >= 0.0) return longint'($rtoi(r + 0.5));
        return -longint'($rtoi(-r + 0.5));
    endfunction

    function automatic longint sat(input longint v);
        if (v > 65535) return 65535;
        if (v < -65536) return -65536;
        return v;
    endfunction

    // Reference: y_k = sum in_m * (-j)^(mk), times W16^(n*k) quantised to Q1.8,
    // floor-shifted by 8, saturated.
    function automatic logic [BUS_W-1:0] ref_model(input logic [BUS_W-1:0] din,
                                                   input logic [2:0] rot);
        logic [BUS_W-1:0] res;
        longint yr, yi, ar, ai, tr, ti, zr, zi, t;
        int p;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            yr = 0;
            yi = 0;
            for (int m = 0; m < 4; m++) begin
                ar = longint'(sre(din, m));
                ai = longint'(sim(din, m));
                // apply (-j)^e by repeated quarter turns
                for (int e = 0; e < (m * k) % 4; e++) begin
                    t  = ar;
                    ar = ai;
                    ai = -t;
                end
                yr += ar;
                yi += ai;
            end
            p  = rot[2] ? 0 : int'(rot[1:0]) * k;
            tr = rnd(256.0 * $cos(2.0 * PI * p / 16.0));
            ti = -rnd(256.0 * $sin(2.0 * PI * p / 16.0));
            zr = sat((yr * tr - yi * ti) >>> 8);
            zi = sat((yr * ti + yi * tr) >>> 8);
            res[k*CW +: CW] = {17'(zr), 17'(zi)};
        end
        return res;
    endfunction

    function automatic logic [BUS_W-1:0] rnd_full();
        logic [BUS_W-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*17 +: 17] = 17'($urandom);
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [BUS_W-1:0] obs,
                         input logic [BUS_W-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int idx, input int obs, input real exp);
        n_tests++;
        assert (real'(obs) >= exp - 3.0 && real'(obs) <= exp + 3.0)
        else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0d expected %f +-3", tag, idx, obs, exp);
        end
    endtask

    // One beat: present inputs on the falling edge, sample 1 time unit after
    // the next rising edge.
    task automatic drive(input logic [BUS_W-1:0] din, input logic [2:0] rot, input logic r);
        @(negedge clk);
        bus.calc_in  = din;
        bus.rotation = rot;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    // Two-pass 16-point FFT of xr/xi into fr/fi, checking every beat.
    task automatic run_fft();
        logic [BUS_W-1:0] s1 [4];
        logic [BUS_W-1:0] din;
        for (int n = 0; n < 4; n++) begin
            din = {mk(xr[n+12], xi[n+12]), mk(xr[n+8], xi[n+8]),
                   mk(xr[n+4], xi[n+4]), mk(xr[n], xi[n])};
            drive(din, 3'(n), 1'b0);
            check("fft_stage1", bus.calc_out, ref_model(din, 3'(n)));
            s1[n] = bus.calc_out;
        end
        for (int j = 0; j < 4; j++) begin
            din = {s1[3][j*CW +: CW], s1[2][j*CW +: CW], s1[1][j*CW +: CW], s1[0][j*CW +: CW]};
            drive(din, 3'(4 + j), 1'b0);
            check("fft_stage2", bus.calc_out, ref_model(din, 3'(4 + j)));
            for (int q = 0; q < 4; q++) begin
                fr[4*q + j] = sre(bus.calc_out, q);
                fi[4*q + j] = sim(bus.calc_out, q);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [BUS_W-1:0] din;
        logic [BUS_W-1:0] exp;
        logic [2:0]       rot;
        real              sr, si, ang;

        rst          = 1'b1;
        bus.calc_in  = '0;
        bus.rotation = '0;

        // 1. reset clears output, has priority over data, release follows data
        din = rnd_full();
        drive(din, 3'b000, 1'b1);
        check("reset_clear", bus.calc_out, '0);
        din = rnd_full();
        drive(din, 3'b011, 1'b0);
        check("reset_release", bus.calc_out, ref_model(din, 3'b011));
        din = rnd_full();
        drive(din, 3'b001, 1'b1);
        check("reset_priority", bus.calc_out, '0);
        din = rnd_full();
        drive(din, 3'b110, 1'b0);
        check("reset_release2", bus.calc_out, ref_model(din, 3'b110));

        // 2. all inputs 1.0, no twiddle
        din = {mk(256, 0), mk(256, 0), mk(256, 0), mk(256, 0)};
        drive(din, 3'b100, 1'b0);
        exp = {mk(0, 0), mk(0, 0), mk(0, 0), mk(1024, 0)};
        check("all_ones", bus.calc_out, exp);

        // 3. only in2 = 1.0, no twiddle
        din = {mk(0, 0), mk(0, 0), mk(256, 0), mk(0, 0)};
        drive(din, 3'b100, 1'b0);
        exp = {mk(0, 256), mk(-256, 0), mk(0, -256), mk(256, 0)};
        check("in2_only", bus.calc_out, exp);

        // 4. only in1 = 1.0, twiddle index 1
        din = {mk(0, 0), mk(0, 0), mk(0, 0), mk(256, 0)};
        drive(din, 3'b001, 1'b0);
        exp = {mk(98, -237), mk(181, -181), mk(237, -98), mk(256, 0)};
        check("twiddle_n1", bus.calc_out, exp);

        // 5a. impulse through the full 16-point flow
        for (int i = 0; i < 16; i++) begin
            xr[i] = 0;
            xi[i] = 0;
        end
        xr[0] = 256;
        run_fft();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("impulse_X%0d", i), {{(BUS_W - CW){1'b0}}, mk(fr[i], fi[i])},
                  {{(BUS_W - CW){1'b0}}, mk(256, 0)});
        end

        // 5b. random small vector vs floating-point DFT
        for (int i = 0; i < 16; i++) begin
            xr[i] = int'($urandom_range(16)) - 8;
            xi[i] = int'($urandom_range(16)) - 8;
        end
        run_fft();
        for (int k = 0; k < 16; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int m = 0; m < 16; m++) begin
                ang = -2.0 * PI * real'(m * k) / 16.0;
                sr += real'(xr[m]) * $cos(ang) - real'(xi[m]) * $sin(ang);
                si += real'(xr[m]) * $sin(ang) + real'(xi[m]) * $cos(ang);
            end
            check_tol("dft_re", k, fr[k], sr);
            check_tol("dft_im", k, fi[k], si);
        end

        // 6. saturation on out1
        din = {mk(65535, -65536), mk(65535, -65536), mk(65535, -65536), mk(65535, -65536)};
        drive(din, 3'b100, 1'b0);
        exp = {mk(0, 0), mk(0, 0), mk(0, 0), mk(65535, -65536)};
        check("saturate", bus.calc_out, exp);

        // 6b. back-to-back beats, rotation changing every cycle
        for (int i = 0; i < 200; i++) begin
            din = rnd_full();
            rot = 3'($urandom);
            drive(din, rot, 1'b0);
            check($sformatf("b2b_%0d_rot%0d", i, rot), bus.calc_out, ref_model(din, rot));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
